// File: rtl/bcd_up_4digit_counter_pkg.sv
// Package for the 4-digit BCD up-counter: FSM state type built from the
// shared encodings, plus derived constants.
`include "global.v"

package bcd_up_4digit_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = `BCD_ST_IDLE,
      ST_RUN   = `BCD_ST_RUN,
      ST_PAUSE = `BCD_ST_PAUSE,
      ST_DONE  = `BCD_ST_DONE
   } state_e;

   localparam int NUM_DIGITS = 4;

endpackage

// File: rtl/bcd_up_4digit_counter_digit.sv
// bcd_digit_up: one BCD digit incrementer (combinational).
//   digit_i : current digit value (0..9)
//   inc_i   : increment enable (carry-in from the lower digit)
//   digit_o : incremented digit, wraps 9 -> 0
//   carry_o : high when the digit wraps while enabled
`include "global.v"

module bcd_digit_up (
   input  logic [3:0] digit_i,
   input  logic       inc_i,
   output logic [3:0] digit_o,
   output logic       carry_o
);

   always_comb begin
      digit_o = digit_i;
      carry_o = 1'b0;
      if (inc_i) begin
         if (digit_i == `BCD_DIGIT_MAX) begin
            digit_o = 4'd0;
            carry_o = 1'b1;
         end else begin
            digit_o = digit_i + 4'd1;
         end
      end
   end

endmodule

// File: rtl/global.v
// Shared constants for the BCD up-counter block: datapath width, zero value,
// largest legal BCD digit and the FSM state encodings.
`ifndef BCD_GLOBAL_V
`define BCD_GLOBAL_V

`define BCD_COUNTER_BITS 16
`define BCD_COUNTER_ZERO 16'h0000
`define BCD_DIGIT_MAX    4'd9

`define BCD_ST_IDLE  2'd0
`define BCD_ST_RUN   2'd1
`define BCD_ST_PAUSE 2'd2
`define BCD_ST_DONE  2'd3

`endif

// File: rtl/bcd_up_4digit_counter.sv
// bcd_up_4digit_counter: four-digit BCD up-counter with start/pause/clear
// control and a captured terminal limit.
//   clk, rst       : clock, synchronous active-high reset
//   tick           : count strobe
//   start          : capture counter_limit and count from 0000
//   pause          : toggle RUN <-> PAUSE
//   clear          : return to IDLE with count 0000
//   counter_limit  : terminal value, packed BCD
//   q              : current count, packed BCD
//   running, done  : state flags
//   done_pulse     : one cycle on entry to DONE
`include "global.v"

module bcd_up_4digit_counter
   import bcd_up_4digit_counter_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         tick,
   input  logic                         start,
   input  logic                         pause,
   input  logic                         clear,
   input  logic [`BCD_COUNTER_BITS-1:0] counter_limit,
   output logic [`BCD_COUNTER_BITS-1:0] q,
   output logic                         running,
   output logic                         done,
   output logic                         done_pulse
);

   state_e                         state_q, state_d;
   logic [`BCD_COUNTER_BITS-1:0]   cnt_q, cnt_d;
   logic [`BCD_COUNTER_BITS-1:0]   limit_q, limit_d;
   logic                           running_q, running_d;
   logic                           done_q, done_d;
   logic                           pulse_q, pulse_d;

   logic [`BCD_COUNTER_BITS-1:0]   cnt_inc;
   logic                           c0, c1, c2, c3;

   // Carry chain: the lowest digit is always enabled, so cnt_inc is cnt_q+1.
   // The carry out of the top digit flags that cnt_q is 9999.
   bcd_digit_up u_dig0 (.digit_i(cnt_q[3:0]),   .inc_i(1'b1), .digit_o(cnt_inc[3:0]),   .carry_o(c0));
   bcd_digit_up u_dig1 (.digit_i(cnt_q[7:4]),   .inc_i(c0),   .digit_o(cnt_inc[7:4]),   .carry_o(c1));
   bcd_digit_up u_dig2 (.digit_i(cnt_q[11:8]),  .inc_i(c1),   .digit_o(cnt_inc[11:8]),  .carry_o(c2));
   bcd_digit_up u_dig3 (.digit_i(cnt_q[15:12]), .inc_i(c2),   .digit_o(cnt_inc[15:12]), .carry_o(c3));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      limit_d = limit_q;
      pulse_d = 1'b0;

      if (clear) begin
         state_d = ST_IDLE;
         cnt_d   = `BCD_COUNTER_ZERO;
      end else if (start) begin
         limit_d = counter_limit;
         cnt_d   = `BCD_COUNTER_ZERO;
         // A zero limit is already reached at the start.
         if (counter_limit == `BCD_COUNTER_ZERO) begin
            state_d = ST_DONE;
            pulse_d = 1'b1;
         end else begin
            state_d = ST_RUN;
         end
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (pause) begin
                  state_d = ST_PAUSE;          // tick in the same cycle is dropped
               end else if (tick) begin
                  if (c3) begin
                     state_d = ST_DONE;        // saturate at 9999
                     pulse_d = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                     if (cnt_inc == limit_q) begin
                        state_d = ST_DONE;
                        pulse_d = 1'b1;
                     end
                  end
               end
            end
            ST_PAUSE: if (pause) state_d = ST_RUN;
            default: ;                         // IDLE and DONE hold
         endcase
      end

      running_d = (state_d == ST_RUN);
      done_d    = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= `BCD_COUNTER_ZERO;
         limit_q   <= `BCD_COUNTER_ZERO;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         pulse_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         limit_q   <= limit_d;
         running_q <= running_d;
         done_q    <= done_d;
         pulse_q   <= pulse_d;
      end
   end

   assign q          = cnt_q;
   assign running    = running_q;
   assign done       = done_q;
   assign done_pulse = pulse_q;

endmodule

// File: tb/tb_bcd_up_4digit_counter.sv
// Self-checking bench for bcd_up_4digit_counter: integer-valued reference
// model compared every cycle, directed scenarios with literal expectations,
// then randomized control traffic.
module tb_bcd_up_4digit_counter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tick = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
   logic [15:0] counter_limit = 16'h0000;
   logic [15:0] q;
   logic        running, done, done_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   bcd_up_4digit_counter dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
      .clear(clear), .counter_limit(counter_limit), .q(q),
      .running(running), .done(done), .done_pulse(done_pulse)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: count kept as a plain integer 0..9999.
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
   int          m_state = M_IDLE;
   int          m_cnt   = 0;
   logic [15:0] m_lim   = 16'h0000;
   logic        m_pulse = 1'b0;
   bit          m_valid = 1'b0;

   always @(posedge clk) begin
      m_pulse <= 1'b0;
      if (rst) begin
         m_valid <= 1'b1;
         m_state <= M_IDLE;
         m_cnt   <= 0;
         m_lim   <= 16'h0000;
      end else if (clear) begin
         m_state <= M_IDLE;
         m_cnt   <= 0;
      end else if (start) begin
         m_lim <= counter_limit;
         m_cnt <= 0;
         if (counter_limit == 16'h0000) begin
            m_state <= M_DONE;
            m_pulse <= 1'b1;
         end else begin
            m_state <= M_RUN;
         end
      end else if (m_state == M_RUN) begin
         if (pause) m_state <= M_PAUSE;
         else if (tick) begin
            if (m_cnt == 9999) begin
               m_state <= M_DONE;
               m_pulse <= 1'b1;
            end else begin
               m_cnt <= m_cnt + 1;
               if (to_bcd(m_cnt + 1) == m_lim) begin
                  m_state <= M_DONE;
                  m_pulse <= 1'b1;
               end
            end
         end
      end else if (m_state == M_PAUSE && pause) begin
         m_state <= M_RUN;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_q",       q,                   to_bcd(m_cnt));
         chk("model_running", 16'(running),        16'(m_state == M_RUN));
         chk("model_done",    16'(done),           16'(m_state == M_DONE));
         chk("model_pulse",   16'(done_pulse),     16'(m_pulse));
      end
   end

   task automatic step(input bit t, input bit s, input bit p, input bit c);
      @(negedge clk);
      tick = t; start = s; pause = p; clear = c;
      @(posedge clk);
      #1;
      tick = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) step(1, 0, 0, 0);
   endtask

   task automatic do_rst;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      // reset state
      do_rst;
      chk("rst_q", q, 16'h0000);
      chk("rst_running", 16'(running), 16'h0);
      chk("rst_done", 16'(done), 16'h0);
      chk("rst_pulse", 16'(done_pulse), 16'h0);

      // limit 0025, 25 ticks
      counter_limit = 16'h0025;
      step(0, 1, 0, 0);
      chk("s25_start_q", q, 16'h0000);
      chk("s25_running", 16'(running), 16'h1);
      for (int i = 1; i <= 25; i++) begin
         step(1, 0, 0, 0);
         chk("s25_q", q, to_bcd(i));
         chk("s25_pulse", 16'(done_pulse), 16'(i == 25));
      end
      step(1, 0, 0, 0);
      chk("s25_hold_q", q, 16'h0025);
      chk("s25_done", 16'(done), 16'h1);
      chk("s25_pulse_once", 16'(done_pulse), 16'h0);

      // limit 0100, carry chain
      counter_limit = 16'h0100;
      step(0, 1, 0, 0);
      ticks(9);
      chk("s100_q9", q, 16'h0009);
      ticks(1);
      chk("s100_q10", q, 16'h0010);
      ticks(89);
      chk("s100_q99", q, 16'h0099);
      chk("s100_run", 16'(running), 16'h1);
      ticks(1);
      chk("s100_q100", q, 16'h0100);
      chk("s100_done", 16'(done), 16'h1);
      chk("s100_pulse", 16'(done_pulse), 16'h1);

      // pause with tick at 0042
      counter_limit = 16'h0500;
      step(0, 1, 0, 0);
      ticks(42);
      chk("pause_q42", q, 16'h0042);
      step(1, 0, 1, 0);
      chk("pause_drop", q, 16'h0042);
      chk("pause_notrun", 16'(running), 16'h0);
      ticks(5);
      chk("pause_hold", q, 16'h0042);
      step(0, 0, 1, 0);
      chk("pause_resume", 16'(running), 16'h1);
      ticks(1);
      chk("pause_q43", q, 16'h0043);

      // limit captured at start, later input changes ignored
      counter_limit = 16'h0003;
      step(0, 1, 0, 0);
      counter_limit = 16'h0002;
      ticks(2);
      chk("cap_not_done", 16'(done), 16'h0);
      ticks(1);
      chk("cap_done", 16'(done), 16'h1);
      chk("cap_q", q, 16'h0003);

      // non-BCD limit saturates at 9999
      counter_limit = 16'h12A4;
      step(0, 1, 0, 0);
      ticks(9999);
      chk("sat_q9999", q, 16'h9999);
      chk("sat_running", 16'(running), 16'h1);
      ticks(1);
      chk("sat_hold", q, 16'h9999);
      chk("sat_done", 16'(done), 16'h1);
      chk("sat_pulse", 16'(done_pulse), 16'h1);
      ticks(1);
      chk("sat_pulse_once", 16'(done_pulse), 16'h0);

      // zero limit, then clear beats start
      counter_limit = 16'h0000;
      step(0, 1, 0, 0);
      chk("zero_done", 16'(done), 16'h1);
      chk("zero_pulse", 16'(done_pulse), 16'h1);
      chk("zero_q", q, 16'h0000);
      counter_limit = 16'h0005;
      step(0, 1, 0, 1);
      chk("clr_q", q, 16'h0000);
      chk("clr_done", 16'(done), 16'h0);
      chk("clr_running", 16'(running), 16'h0);

      // reset mid-count
      counter_limit = 16'h0500;
      step(0, 1, 0, 0);
      ticks(307);
      chk("mid_q307", q, 16'h0307);
      do_rst;
      chk("mid_rst_q", q, 16'h0000);
      chk("mid_rst_running", 16'(running), 16'h0);
      chk("mid_rst_done", 16'(done), 16'h0);
      chk("mid_rst_pulse", 16'(done_pulse), 16'h0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst   = ($urandom_range(0, 299) == 0);
         tick  = $urandom_range(0, 1) == 1;
         start = ($urandom_range(0, 39) == 0);
         pause = ($urandom_range(0, 19) == 0);
         clear = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 3) == 0)
            counter_limit = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                        : to_bcd(int'($urandom_range(0, 40)));
      end
      @(negedge clk);
      rst = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
